// File: rtl/boot_loader_fsm.sv
// Byte-stream program loader: frames SYNC/LEN/data words into the CPU's external memory port
// and holds the CPU in reset until the image is written. Optional checksum: LOADER_CHECKSUM_EN.
module boot_loader_fsm #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 64,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        cpu_reset,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_WriteData,
    output logic [31:0] Ext_DataAdr,
    output logic [15:0] words_loaded,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_FIN   = S_CSUM;
`else
    localparam logic [2:0] S_FIN   = S_DONE;
`endif

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]    MAX_N    = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    // Running modulo-256 sum of the data bytes of a frame.
    function automatic logic [7:0] f_csum_add(input logic [7:0] sum, input logic [7:0] data);
        f_csum_add = sum + data;
    endfunction
`endif

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_rx_ready;
    logic          r_cpu_rst;
    logic          r_done;
    logic          r_err;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [31:0]   r_adr;
    logic [15:0]   r_len;
    logic [15:0]   r_words;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_word;
    logic [TW-1:0] r_tmo;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic          w_accept;
    logic          w_sync;
    logic [15:0]   w_len_full;
    logic          w_tmo_active;
    logic          w_tmo_hit;
    logic          w_word_done;

    assign w_accept    = rx_valid & r_rx_ready;
    assign w_sync      = w_accept & (rx_data == SYNC_BYTE);
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_word_done = (r_state == S_DATA) & w_accept & (r_byte_idx == 2'd3);
    assign w_tmo_hit   = w_tmo_active & ~w_accept & (r_tmo == TMO_LAST);

    // Timeout is armed only while a frame is in progress and a byte is awaited.
    always_comb begin
        w_tmo_active = 1'b0;
        case (r_state)
            S_LEN0, S_LEN1, S_DATA: w_tmo_active = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                 w_tmo_active = 1'b1;
`endif
            default:                w_tmo_active = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_sync) begin
                    w_state_nxt = S_LEN0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_LEN0: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end else if (w_accept) begin
                    w_state_nxt = S_LEN1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_LEN1: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end else if (w_accept) begin
                    if (w_len_full == 16'd0) begin
                        w_state_nxt = S_FIN;
                    end else if (w_len_full > MAX_N) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_DATA: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end else if (w_word_done) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_WRITE: begin
                if ((r_words + 16'd1) == r_len) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_tmo_hit) begin
                    w_state_nxt = S_ERROR;
                end else if (w_accept) begin
                    if (rx_data == r_csum) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and status outputs, all registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= (w_state_nxt != S_WRITE);
            r_cpu_rst  <= (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_ERROR);
        end
    end

    // Idle-cycle counter, restarted by every accepted byte and every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (w_accept || (w_state_nxt != r_state)) begin
            r_tmo <= '0;
        end else if (w_tmo_active) begin
            r_tmo <= r_tmo + TW'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    // Frame bookkeeping: length, byte lane, partial word and word count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len      <= 16'd0;
            r_words    <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_sync) begin
                        r_words <= 16'd0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        r_byte_idx  <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0:    r_word[7:0]   <= rx_data;
                            2'd1:    r_word[15:8]  <= rx_data;
                            2'd2:    r_word[23:16] <= rx_data;
                            default: r_word        <= r_word;
                        endcase
                    end
                end
                S_WRITE: r_words <= r_words + 16'd1;
                default: r_words <= r_words;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum accumulator over the data bytes, restarted by SYNC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csum <= 8'd0;
        end else if (w_sync && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR))) begin
            r_csum <= 8'd0;
        end else if ((r_state == S_DATA) && w_accept) begin
            r_csum <= f_csum_add(r_csum, rx_data);
        end
    end
`endif

    // Memory port: strobe is high for exactly the WRITE cycle; data/address hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_adr   <= ADDR_BASE;
        end else begin
            r_we <= (w_state_nxt == S_WRITE);
            if (w_word_done) begin
                r_wdata <= {rx_data, r_word};
                r_adr   <= ADDR_BASE + {14'd0, r_words, 2'b00};
            end else if ((r_state == S_LEN1) && (w_state_nxt == S_DATA)) begin
                r_adr <= ADDR_BASE;
            end
        end
    end

    assign rx_ready      = r_rx_ready;
    assign cpu_reset     = r_cpu_rst;
    assign Ext_MemWrite  = r_we;
    assign Ext_WriteData = r_wdata;
    assign Ext_DataAdr   = r_adr;
    assign words_loaded  = r_words;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_boot_loader_fsm.sv
// Scoreboard bench for boot_loader_fsm: expected memory writes are queued by the stimulus
// and popped by a monitor on every write strobe; status outputs are checked directly.
module tb_boot_loader_fsm;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        cpu_reset;
    logic        Ext_MemWrite;
    logic [31:0] Ext_WriteData;
    logic [31:0] Ext_DataAdr;
    logic [15:0] words_loaded;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q [$];

    boot_loader_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .cpu_reset     (cpu_reset),
        .Ext_MemWrite  (Ext_MemWrite),
        .Ext_WriteData (Ext_WriteData),
        .Ext_DataAdr   (Ext_DataAdr),
        .words_loaded  (words_loaded),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_write(input logic [31:0] adr, input logic [31:0] data);
        exp_q.push_back({adr, data});
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset && Ext_MemWrite) begin
            check("wr_rx_ready_low", {31'd0, rx_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: adr %h data %h with no write expected",
                         Ext_DataAdr, Ext_WriteData);
            end else begin
                e = exp_q.pop_front();
                check("wr_adr", Ext_DataAdr, e[63:32]);
                check("wr_data", Ext_WriteData, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        waited = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            n_checks++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready %b", b, rx_ready);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (gap) rx_valid = 1'b0;
        end
    endtask

    task automatic send_bytes(input bq_t b, input bit gap);
        foreach (b[i]) send_byte(b[i], gap);
    endtask

    // Sends a full frame; with the checksum build the sum of data bytes (xor csum_xor) follows.
    task automatic send_frame(input bq_t b, input bit gap, input logic [7:0] csum_xor);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 3; i < b.size(); i++) sum = sum + b[i];
        send_bytes(b, gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum ^ csum_xor, gap);
`else
        if (csum_xor != 8'h00) $display("note: checksum build disabled, sum %h unused", sum);
`endif
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t t2;
        t2 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};

        // T1: reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_memwrite", {31'd0, Ext_MemWrite}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        check("rst_adr", Ext_DataAdr, 32'h0000_0000);
        check("rst_wdata", Ext_WriteData, 32'h0000_0000);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);

        // T2: two-word image with gaps between bytes
        expect_write(32'h0000_0000, 32'h0000_0513);
        expect_write(32'h0000_0004, 32'h0010_0293);
        send_frame(t2, 1'b1, 8'h00);
        idle(3);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("t2_words", {16'd0, words_loaded}, 32'd2);
        check("t2_err", {31'd0, err}, 32'd0);
        check("t2_adr_hold", Ext_DataAdr, 32'h0000_0004);
        check("t2_wdata_hold", Ext_WriteData, 32'h0010_0293);
        check("t2_q_empty", exp_q.size(), 32'd0);

        // T3: N = 65 rejected
        send_bytes('{8'hA5, 8'h41, 8'h00}, 1'b1);
        idle(3);
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("t3_done", {31'd0, done}, 32'd0);
        check("t3_words", {16'd0, words_loaded}, 32'd0);

        // N = 64 accepted; one word then stall until timeout
        expect_write(32'h0000_0000, 32'hDDCC_BBAA);
        send_bytes('{8'hA5, 8'h40, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b1);
        idle(3);
        check("n64_err", {31'd0, err}, 32'd0);
        check("n64_words", {16'd0, words_loaded}, 32'd1);
        idle(1100);
        check("n64_tmo_err", {31'd0, err}, 32'd1);

        // T4: timeout mid-word, then recovery on SYNC
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22}, 1'b1);
        idle(1000);
        check("t4_no_err_early", {31'd0, err}, 32'd0);
        idle(30);
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'hA5, 1'b1);
        idle(0);
        check("t4_err_cleared", {31'd0, err}, 32'd0);
        check("t4_words_cleared", {16'd0, words_loaded}, 32'd0);
        expect_write(32'h0000_0000, 32'h1234_5678);
        send_bytes('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h14, 1'b1);
`endif
        idle(3);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_words", {16'd0, words_loaded}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // T5: bad checksum (0xBB against a sum of 0xBD)
        expect_write(32'h0000_0000, 32'h0000_0513);
        expect_write(32'h0000_0004, 32'h0010_0293);
        send_frame(t2, 1'b1, 8'h06);
        idle(3);
        check("t5_err", {31'd0, err}, 32'd1);
        check("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_words", {16'd0, words_loaded}, 32'd2);
`endif

        // T6: rx_valid held high back-to-back through the writes
        expect_write(32'h0000_0000, 32'h0000_0513);
        expect_write(32'h0000_0004, 32'h0010_0293);
        send_frame(t2, 1'b0, 8'h00);
        idle(3);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("t6_words", {16'd0, words_loaded}, 32'd2);
        check("t6_q_empty", exp_q.size(), 32'd0);

        // Async reset mid-frame: partial word is dropped, no strobe afterwards
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33}, 1'b1);
        reset = 1'b0;
        #2;
        check("ar_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("ar_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("ar_words", {16'd0, words_loaded}, 32'd0);
        check("ar_adr", Ext_DataAdr, 32'h0000_0000);
        check("ar_wdata", Ext_WriteData, 32'h0000_0000);
        idle(2);
        reset = 1'b1;
        send_bytes('{8'h44, 8'h11}, 1'b1);
        idle(3);
        check("ar_idle_done", {31'd0, done}, 32'd0);
        check("ar_idle_words", {16'd0, words_loaded}, 32'd0);
        expect_write(32'h0000_0000, 32'hCAFE_F00D);
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA}, 1'b1, 8'h00);
        idle(3);
        check("ar_reload_done", {31'd0, done}, 32'd1);
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
